// File: rtl/dlfloat_pkg.sv
// Shared constants for the DLFloat datapath: rounding-mode encodings,
// exception-flag bit positions and the packed word width helper.
package dlfloat_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RUP = 3'b010;
    localparam logic [2:0] RM_RDN = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int FLG_INEXACT = 0;
    localparam int FLG_OVF     = 1;
    localparam int FLG_INVRM   = 2;
    localparam int FLG_NAN     = 3;

    function automatic int out_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

endpackage

// File: rtl/dlfloat_round_core.sv
// Combinational rounding datapath: decodes guard/sticky, picks the increment
// for the rounding mode, adds it to {exp, mant} and saturates on overflow.
module dlfloat_round_core
    import dlfloat_pkg::*;
#(
    parameter int EXP_W = 6,
    parameter int MAN_W = 9,
    parameter int GRS_W = 4,
    localparam int OUT_W = out_width(EXP_W, MAN_W)
) (
    input  logic             sign_i,
    input  logic [EXP_W-1:0] exp_i,
    input  logic [MAN_W-1:0] man_i,
    input  logic [GRS_W-1:0] extra_i,
    input  logic [2:0]       rm_i,
    output logic [OUT_W-1:0] word_o,
    output logic [3:0]       flags_o
);

    localparam int EM_W = EXP_W + MAN_W;
    localparam logic [EM_W-1:0] MAX_FINITE = {{(EM_W-1){1'b1}}, 1'b0};

    logic            guard;
    logic            sticky;
    logic            lsb;
    logic            inc;
    logic            invalid_rm;
    logic            is_nan;
    logic            overflow;
    logic [EM_W-1:0] em;
    logic [EM_W:0]   sum;

    assign em = {exp_i, man_i};

    always_comb begin
        guard      = extra_i[GRS_W-1];
        sticky     = |extra_i[GRS_W-2:0];
        lsb        = man_i[0];
        inc        = 1'b0;
        invalid_rm = 1'b0;

        case (rm_i)
            RM_RNE: inc = guard & (sticky | lsb);
            RM_RTZ: inc = 1'b0;
            RM_RUP: inc = (guard | sticky) & ~sign_i;
            RM_RDN: inc = (guard | sticky) & sign_i;
            RM_RMM: inc = guard;
            default: begin
                inc        = guard & (sticky | lsb);
                invalid_rm = 1'b1;
            end
        endcase

        // A mantissa carry ripples naturally into the exponent field.
        sum      = {1'b0, em} + {{EM_W{1'b0}}, inc};
        is_nan   = &em;
        overflow = sum[EM_W] | (&sum[EM_W-1:0]);

        flags_o = '0;
        if (is_nan) begin
            word_o           = {sign_i, {EM_W{1'b1}}};
            flags_o[FLG_NAN] = 1'b1;
        end else if (overflow) begin
            word_o               = {sign_i, MAX_FINITE};
            flags_o[FLG_OVF]     = 1'b1;
            flags_o[FLG_INEXACT] = 1'b1;
            flags_o[FLG_INVRM]   = invalid_rm;
        end else begin
            word_o               = {sign_i, sum[EM_W-1:0]};
            flags_o[FLG_INEXACT] = guard | sticky;
            flags_o[FLG_INVRM]   = invalid_rm;
        end
    end

endmodule

// File: rtl/dlfloat_round_pipe.sv
// Two-stage DLFloat rounding pipeline with valid/ready handshake and full
// backpressure: S1 captures the operand, S2 holds the rounded result.
module dlfloat_round_pipe
    import dlfloat_pkg::*;
#(
    parameter int EXP_W = 6,
    parameter int MAN_W = 9,
    parameter int GRS_W = 4,
    localparam int OUT_W = out_width(EXP_W, MAN_W)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OUT_W+GRS_W-1:0] in_data,
    input  logic [2:0]             in_rm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic [3:0]             out_flags
);

    localparam int IN_W = OUT_W + GRS_W;

    logic             s1_valid_q, s1_valid_d;
    logic [IN_W-1:0]  s1_data_q,  s1_data_d;
    logic [2:0]       s1_rm_q,    s1_rm_d;
    logic             s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0] s2_data_q,  s2_data_d;
    logic [3:0]       s2_flags_q, s2_flags_d;

    logic             s2_advance;
    logic [OUT_W-1:0] core_word;
    logic [3:0]       core_flags;

    dlfloat_round_core #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .GRS_W (GRS_W)
    ) u_core (
        .sign_i  (s1_data_q[IN_W-1]),
        .exp_i   (s1_data_q[IN_W-2 -: EXP_W]),
        .man_i   (s1_data_q[GRS_W +: MAN_W]),
        .extra_i (s1_data_q[GRS_W-1:0]),
        .rm_i    (s1_rm_q),
        .word_o  (core_word),
        .flags_o (core_flags)
    );

    // S1 may refill whenever its word is leaving, so only a stalled output
    // with a full S1 blocks the input.
    assign s2_advance = ~s2_valid_q | out_ready;
    assign in_ready   = ~s1_valid_q | s2_advance;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_rm_d    = s1_rm_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_flags_d = s2_flags_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_rm_d   = in_rm;
            end
        end

        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d  = core_word;
                s2_flags_d = core_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_rm_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_flags_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_rm_q    <= s1_rm_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_flags_q <= s2_flags_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_flags = s2_flags_q;

endmodule

// File: tb/tb_dlfloat_round_pipe.sv
// Directed-vector bench for dlfloat_round_pipe: per-vector latency and value
// checks, a randomly backpressured stream, and an asynchronous mid-stream reset.
module tb_dlfloat_round_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_data = '0;
    logic [2:0]  in_rm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [3:0]  out_flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [19:0] din;
        logic [2:0]  rm;
        logic [15:0] dout;
        logic [3:0]  flags;
        string       name;
    } vec_t;

    vec_t vecs[16];

    dlfloat_round_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rm     (in_rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Single isolated transfer: checks acceptance, exact 2-cycle latency and result.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = v.din;
        in_rm     = v.rm;
        #1;
        check({v.name, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({v.name, " early_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check({v.name, " out_valid"}, 32'(out_valid), 32'd1);
        check({v.name, " data"}, 32'(out_data), 32'(v.dout));
        check({v.name, " flags"}, 32'(out_flags), 32'(v.flags));
        $display("vec %-14s in=%h rm=%b -> data=%h flags=%b", v.name, v.din, v.rm, out_data, out_flags);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   sent;
        int   recv;
        int   cycles;
        logic hold_pending;
        logic [15:0] held_data;
        logic [3:0]  held_flags;
        logic acc;
        logic xfer;

        vecs[0]  = '{20'h21FF8, 3'b000, 16'h2200, 4'b0001, "rne_carry"};
        vecs[1]  = '{20'h21008, 3'b000, 16'h2100, 4'b0001, "rne_tie_even"};
        vecs[2]  = '{20'h21008, 3'b100, 16'h2101, 4'b0001, "rmm_tie"};
        vecs[3]  = '{20'h7FFE1, 3'b010, 16'h7FFE, 4'b0011, "rup_ovf"};
        vecs[4]  = '{20'hFFFE1, 3'b010, 16'hFFFE, 4'b0001, "rup_neg"};
        vecs[5]  = '{20'hFFFE1, 3'b011, 16'hFFFE, 4'b0011, "rdn_ovf"};
        vecs[6]  = '{20'h7FFFF, 3'b000, 16'h7FFF, 4'b1000, "nan"};
        vecs[7]  = '{20'h21FF8, 3'b111, 16'h2200, 4'b0101, "bad_rm"};
        vecs[8]  = '{20'h21FF8, 3'b001, 16'h21FF, 4'b0001, "rtz"};
        vecs[9]  = '{20'h12340, 3'b000, 16'h1234, 4'b0000, "exact"};
        vecs[10] = '{20'h01FFC, 3'b000, 16'h0200, 4'b0001, "denorm_carry"};
        vecs[11] = '{20'h81008, 3'b011, 16'h8101, 4'b0001, "rdn_neg_tie"};
        vecs[12] = '{20'h80001, 3'b100, 16'h8000, 4'b0001, "rmm_sticky"};
        vecs[13] = '{20'h21008, 3'b101, 16'h2100, 4'b0101, "bad_rm_101"};
        vecs[14] = '{20'h7FFEC, 3'b000, 16'h7FFE, 4'b0011, "rne_ovf"};
        vecs[15] = '{20'hFFFF3, 3'b111, 16'hFFFF, 4'b1000, "nan_neg_badrm"};

        // Reset state
        #2;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        check("rst out_flags", 32'(out_flags), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure stream of 8 words with random out_ready.
        sent = 0;
        recv = 0;
        cycles = 0;
        hold_pending = 1'b0;
        held_data = '0;
        held_flags = '0;
        while ((sent < 8 || recv < 8) && cycles < 300) begin
            @(negedge clk);
            cycles++;
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 8) begin
                in_valid = 1'b1;
                in_data  = vecs[sent].din;
                in_rm    = vecs[sent].rm;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (hold_pending) begin
                check("stall valid", 32'(out_valid), 32'd1);
                check("stall data", 32'(out_data), 32'(held_data));
                check("stall flags", 32'(out_flags), 32'(held_flags));
            end
            check("bp in_ready", 32'(in_ready), 32'(!((sent - recv) == 2 && !out_ready)));
            acc  = in_valid & in_ready;
            xfer = out_valid & out_ready;
            if (xfer) begin
                if (recv < 8) begin
                    check("bp data", 32'(out_data), 32'(vecs[recv].dout));
                    check("bp flags", 32'(out_flags), 32'(vecs[recv].flags));
                    $display("bp  out #%0d data=%h flags=%b cycle=%0d", recv, out_data, out_flags, cycles);
                end else begin
                    check("bp extra output", 32'(recv), 32'd7);
                end
                recv++;
            end
            hold_pending = out_valid & ~out_ready;
            held_data    = out_data;
            held_flags   = out_flags;
            if (acc) sent++;
        end
        check("bp completed", 32'(recv), 32'd8);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp no dup", 32'(out_valid), 32'd0);
        end

        // Reset with two words in flight.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = vecs[0].din;
        in_rm    = vecs[0].rm;
        @(negedge clk);
        in_data  = vecs[1].din;
        in_rm    = vecs[1].rm;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        check("pre-rst valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async rst valid", 32'(out_valid), 32'd0);
        check("async rst data", 32'(out_data), 32'd0);
        check("async rst flags", 32'(out_flags), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("in rst valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = vecs[2].din;
        in_rm    = vecs[2].rm;
        #1;
        check("post-rst in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("post-rst early", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("post-rst valid", 32'(out_valid), 32'd1);
        check("post-rst data", 32'(out_data), 32'(vecs[2].dout));
        check("post-rst flags", 32'(out_flags), 32'(vecs[2].flags));
        $display("rst post-release data=%h flags=%b", out_data, out_flags);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("post-rst drained", 32'(out_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dlfloat_round_pipe.md
Name: dlfloat_round_pipe

Overview:
- Parametrised, pipelined rounding stage for the DLFloat datapath.
- Sits after the adder/multiplier normalisers. Takes a normalised sign/exponent/mantissa word with extra low-order bits and produces a rounded DLFloat word.
- Supports five rounding modes, saturating overflow, NaN pass-through, exception flags and a valid/ready handshake with full backpressure.
- Generalises the single-register DLFloat16 rounder to arbitrary exponent, mantissa and guard widths.

Parameters:
- EXP_W, 6, exponent field width.
- MAN_W, 9, stored mantissa width (no hidden bit).
- GRS_W, 4, extra bits below the mantissa LSB; must be ≥ 2. The MSB is guard; all remaining bits are OR-ed into sticky.
- OUT_W (derived), 1+EXP_W+MAN_W, output word width; not overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  stage can accept an input this cycle.
- in_data  in  OUT_W+GRS_W  {sign, exp, mant, extra}.
- in_rm  in  3  rounding mode, captured with in_data.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OUT_W  rounded {sign, exp, mant}.
- out_flags  out  4  {nan, invalid_rm, overflow, inexact}.

Behaviour:
- Reset is asynchronous, active-low, on clk. During reset: out_valid=0, out_data=0, out_flags=0, all internal valid bits = 0.
- Pipeline: S1 registers in_data and in_rm. S2 computes the rounding combinationally from S1 and registers out_data/out_flags. Latency is exactly 2 cycles from an accepted input to out_valid when there is no stall.
- Accepts: input transfers when in_valid & in_ready; output transfers when out_valid & out_ready.
- Ready logic: in_ready = !s1_valid | s2_advance, where s2_advance = !out_valid | out_ready. in_ready is combinational from out_ready; there is no combinational in_valid→out path.
- Throughput: one result per cycle when out_ready is held high.
- Stall: while out_valid & !out_ready, out_data and out_flags hold stable and no data is lost or duplicated.
- Decoding: G = extra[GRS_W-1]; S = |extra[GRS_W-2:0]; L = mant[0]; inexact = G|S.
- Round-up increment (inc) by in_rm:
  - 000 RNE: inc = G & (S | L).
  - 001 RTZ: inc = 0.
  - 010 RUP: inc = (G|S) & !sign.
  - 011 RDN: inc = (G|S) & sign.
  - 100 RMM: inc = G.
  - 101–111: treated as RNE and set invalid_rm.
- Increment: {exp, mant} + inc, computed as one (EXP_W+MAN_W+1)-bit add. A mantissa carry increments the exponent; the mantissa wraps to 0.
- NaN/inf code: exp and mant all ones. If the input already carries this code, output = {sign, all ones}, nan=1, other flags 0, no rounding.
- Overflow: if the sum equals the NaN code or carries out of EXP_W+MAN_W, output saturates to max finite {sign, all-ones exp, all-ones mant minus 1}, with overflow=1 and inexact=1.
- Zero/denormal inputs (exp=0) are rounded identically; no flushing.
- Reset asserted mid-operation discards all in-flight words; the first input after reset release is accepted on the first clk edge with in_valid=1.

Decomposition:
- Package dlfloat_pkg holds:
  - rounding-mode constants RM_RNE=3'b000, RM_RTZ=3'b001, RM_RUP=3'b010, RM_RDN=3'b011, RM_RMM=3'b100;
  - flag bit indices FLG_INEXACT=0, FLG_OVF=1, FLG_INVRM=2, FLG_NAN=3;
  - a function computing OUT_W from EXP_W and MAN_W.
- One combinational sub-module, dlfloat_round_core (same parameters), computes inc, the sum, saturation and flags. The top level holds only the S1/S2 registers and the handshake.

Test Plan:
- RNE tie, odd LSB, mantissa carry: in_data=0x21FF8, rm=000 → out_data=0x2200, flags=0001, 2 cycles after accept.
- RNE vs RMM tie, even LSB: in_data=0x21008 with rm=000 → 0x2100, flags=0001. Same input with rm=100 → 0x2101, flags=0001.
- Directed modes and overflow:
  - in_data=0x7FFE1, rm=010 → 0x7FFE (saturated), flags=0011.
  - Same input with sign set (0xFFFE1), rm=010 → 0xFFFE, flags=0001.
  - 0xFFFE1, rm=011 → 0xFFFE, flags=0011.
- NaN and invalid rm:
  - in_data=0x7FFFF, rm=000 → 0x7FFF, flags=1000.
  - in_data=0x21FF8, rm=111 → 0x2200, flags=0101.
- Backpressure: stream 8 back-to-back words with out_ready toggling randomly. The outputs must match a reference model in order with no loss or duplication. out_data must stay stable while out_ready=0, and in_ready must drop only when both stages are full.
- Reset mid-stream: assert rst_n=0 with 2 words in flight. out_valid must drop asynchronously. After release, only post-reset inputs appear, each with 2-cycle latency.
